bits2bytes_stream_ctrl: RTL and testbench

BITS2BYTES_STREAM_CTRL -- requirements
Module: bits2bytes_stream_ctrl

---
 rtl/bits2bytes_stream_ctrl_if.sv | 25 ++
 rtl/bits2bytes_stream_ctrl.sv | 81 ++++++++
 tb/tb_bits2bytes_stream_ctrl.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/bits2bytes_stream_ctrl_if.sv
// bits2bytes_stream_ctrl_if: start/input/output handshake bundle of the bit-to-byte packer
interface bits2bytes_stream_ctrl_if #(
    parameter int IN_W = 1
);
    logic            start_i;
    logic            in_valid_i;
    logic            in_ready_o;
    logic [IN_W-1:0] in_bits_i;
    logic            out_valid_o;
    logic            out_ready_i;
    logic [7:0]      out_byte_o;
    logic            out_last_o;
    logic            busy_o;
    logic            done_o;

    modport slave (
        input  start_i, in_valid_i, in_bits_i, out_ready_i,
        output in_ready_o, out_valid_o, out_byte_o, out_last_o, busy_o, done_o
    );

    modport master (
        output start_i, in_valid_i, in_bits_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_byte_o, out_last_o, busy_o, done_o
    );
endinterface

// File: rtl/bits2bytes_stream_ctrl.sv
// bits2bytes_stream_ctrl: packs an IN_W-bit beat stream into N_BYTES bytes, then drains them in order
module bits2bytes_stream_ctrl #(
    parameter int N_BYTES = 32,
    parameter int IN_W    = 1
) (
    input logic clk_i,
    input logic rst_i,
    bits2bytes_stream_ctrl_if.slave bus
);
    localparam int TOTAL = 8 * N_BYTES;
    localparam int CW    = $clog2(TOTAL + 1);
    localparam int KW    = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic [KW-1:0] k_q;
    logic [7:0]    mem_q [N_BYTES];
    logic          done_q;
    logic          in_hs, out_hs, fill_end, last_byte;
    logic [KW-1:0] wr_idx;

    assign in_hs     = (state_q == FILL) && bus.in_valid_i;
    assign out_hs    = (state_q == DRAIN) && bus.out_ready_i;
    assign fill_end  = in_hs && (cnt_q == CW'(TOTAL - IN_W));
    assign last_byte = (k_q == KW'(N_BYTES - 1));
    assign wr_idx    = cnt_q[3 +: KW];

    // state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // next state and handshake outputs, all decoded from the registered state
    always_comb begin
        state_d         = state_q;
        bus.in_ready_o  = 1'b0;
        bus.out_valid_o = 1'b0;
        bus.out_last_o  = 1'b0;
        bus.out_byte_o  = 8'h00;
        bus.busy_o      = (state_q != IDLE);
        bus.done_o      = done_q;
        unique case (state_q)
            IDLE:  state_d = bus.start_i ? FILL : IDLE;
            FILL: begin
                bus.in_ready_o = 1'b1;
                state_d        = fill_end ? DRAIN : FILL;
            end
            DRAIN: begin
                bus.out_valid_o = 1'b1;
                bus.out_last_o  = last_byte;
                bus.out_byte_o  = mem_q[k_q];
                state_d         = (out_hs && last_byte) ? IDLE : DRAIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // bit counter, byte index, packing buffer and done pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            k_q    <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < N_BYTES; i++) mem_q[i] <= '0;
        end else begin
            done_q <= out_hs && last_byte;
            if (state_q == IDLE && bus.start_i) begin
                cnt_q <= '0;
                k_q   <= '0;
            end
            if (in_hs) begin
                mem_q[wr_idx][cnt_q[2:0] +: IN_W] <= bus.in_bits_i;
                cnt_q <= cnt_q + CW'(IN_W);
            end
            if (out_hs && !last_byte) k_q <= k_q + KW'(1);
        end
    end
endmodule

// File: tb/tb_bits2bytes_stream_ctrl.sv
// tb_bits2bytes_stream_ctrl: directed table-driven bench for the bit-to-byte packer (IN_W=1 and IN_W=4)
module tb_bits2bytes_stream_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bits2bytes_stream_ctrl_if #(.IN_W(1)) a();
    bits2bytes_stream_ctrl_if #(.IN_W(4)) b();

    bits2bytes_stream_ctrl #(.N_BYTES(2), .IN_W(1)) dut_a (.clk_i(clk), .rst_i(rst), .bus(a.slave));
    bits2bytes_stream_ctrl #(.N_BYTES(2), .IN_W(4)) dut_b (.clk_i(clk), .rst_i(rst), .bus(b.slave));

    typedef struct {
        string       name;
        logic [15:0] stream;
        bit          gaps;
        int          bp;
        bit          sst;
        logic [7:0]  e0;
        logic [7:0]  e1;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic idle_a(input string n);
        chk({n, "_in_ready"}, a.in_ready_o, 0);
        chk({n, "_valid"}, a.out_valid_o, 0);
        chk({n, "_byte"}, a.out_byte_o, 0);
        chk({n, "_last"}, a.out_last_o, 0);
        chk({n, "_busy"}, a.busy_o, 0);
        chk({n, "_done"}, a.done_o, 0);
    endtask

    task automatic start_a();
        @(negedge clk);
        a.start_i = 1'b1;
        @(negedge clk);
        a.start_i = 1'b0;
    endtask

    task automatic send_a(input logic [15:0] s, input int n, input bit gaps);
        int   i = 0;
        int   g = 0;
        logic v;
        while (i < n && g < 400) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            a.in_valid_i = v;
            a.in_bits_i  = v ? s[i] : 1'($urandom);
            v = v && a.in_ready_o;
            @(negedge clk);
            i += int'(v);
            g++;
        end
        a.in_valid_i = 1'b0;
        chk("send_in_time", g < 400, 1);
    endtask

    task automatic recv_a(input logic [7:0] e0, input logic [7:0] e1, input int bp, input bit sst);
        for (int c = 0; c < bp; c++) begin
            a.out_ready_i = 1'b0;
            a.start_i     = sst;
            chk("stall_valid", a.out_valid_o, 1);
            chk("stall_byte", a.out_byte_o, e0);
            chk("stall_last", a.out_last_o, 0);
            @(negedge clk);
        end
        a.start_i     = 1'b0;
        a.out_ready_i = 1'b1;
        chk("byte0", a.out_byte_o, e0);
        chk("valid0", a.out_valid_o, 1);
        chk("last0", a.out_last_o, 0);
        chk("done_early", a.done_o, 0);
        @(negedge clk);
        chk("byte1", a.out_byte_o, e1);
        chk("valid1", a.out_valid_o, 1);
        chk("last1", a.out_last_o, 1);
        @(negedge clk);
        chk("done_pulse", a.done_o, 1);
        chk("post_valid", a.out_valid_o, 0);
        chk("post_busy", a.busy_o, 0);
        chk("post_byte", a.out_byte_o, 0);
    endtask

    task automatic run_b(input logic [15:0] beats, input logic [7:0] e0, input logic [7:0] e1);
        int   i = 0;
        int   g = 0;
        logic hs;
        @(negedge clk);
        b.start_i = 1'b1;
        @(negedge clk);
        b.start_i = 1'b0;
        while (i < 4 && g < 50) begin
            b.in_valid_i = 1'b1;
            b.in_bits_i  = beats[4*i +: 4];
            hs = b.in_ready_o;
            @(negedge clk);
            i += int'(hs);
            g++;
        end
        b.in_valid_i = 1'b0;
        chk("w4_in_time", g < 50, 1);
        chk("w4_valid0", b.out_valid_o, 1);
        chk("w4_byte0", b.out_byte_o, e0);
        @(negedge clk);
        chk("w4_byte1", b.out_byte_o, e1);
        chk("w4_last1", b.out_last_o, 1);
        @(negedge clk);
        chk("w4_done", b.done_o, 1);
        chk("w4_busy", b.busy_o, 0);
        @(negedge clk);
        chk("w4_done_off", b.done_o, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vt[0] = '{"basic",   16'h0F0D, 1'b0, 0, 1'b0, 8'h0D, 8'h0F};
        vt[1] = '{"gaps",    16'h0F0D, 1'b1, 0, 1'b0, 8'h0D, 8'h0F};
        vt[2] = '{"stall5",  16'h0F0D, 1'b0, 5, 1'b1, 8'h0D, 8'h0F};
        vt[3] = '{"pat_a5",  16'hA53C, 1'b0, 0, 1'b0, 8'h3C, 8'hA5};
        vt[4] = '{"ones",    16'hFFFF, 1'b1, 1, 1'b0, 8'hFF, 8'hFF};
        vt[5] = '{"edges",   16'h8001, 1'b0, 2, 1'b1, 8'h01, 8'h80};

        rst = 1'b1;
        a.start_i = 0; a.in_valid_i = 0; a.in_bits_i = 0; a.out_ready_i = 0;
        b.start_i = 0; b.in_valid_i = 0; b.in_bits_i = 0; b.out_ready_i = 1;
        repeat (2) @(negedge clk);
        idle_a("reset");
        rst = 1'b0;
        a.in_valid_i = 1'b1;
        repeat (3) @(negedge clk);
        idle_a("post_reset");
        a.in_valid_i = 1'b0;

        foreach (vt[i]) begin
            start_a();
            chk({vt[i].name, "_in_ready"}, a.in_ready_o, 1);
            send_a(vt[i].stream, 16, vt[i].gaps);
            chk({vt[i].name, "_latency"}, a.out_valid_o, 1);
            recv_a(vt[i].e0, vt[i].e1, vt[i].bp, vt[i].sst);
            @(negedge clk);
            chk({vt[i].name, "_done_off"}, a.done_o, 0);
        end

        start_a();
        send_a(16'h0F0D, 16, 1'b0);
        recv_a(8'h0D, 8'h0F, 0, 1'b0);
        a.start_i = 1'b1;
        @(negedge clk);
        a.start_i = 1'b0;
        chk("b2b_busy", a.busy_o, 1);
        chk("b2b_in_ready", a.in_ready_o, 1);
        chk("b2b_done_off", a.done_o, 0);
        send_a(16'hA53C, 16, 1'b0);
        recv_a(8'h3C, 8'hA5, 0, 1'b0);
        @(negedge clk);

        start_a();
        send_a(16'h0F0D, 9, 1'b0);
        chk("mid_fill_busy", a.busy_o, 1);
        rst = 1'b1;
        #1;
        idle_a("rst_fill");
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        idle_a("rst_fill_after");
        start_a();
        send_a(16'h0F0D, 16, 1'b0);
        recv_a(8'h0D, 8'h0F, 0, 1'b0);
        @(negedge clk);

        start_a();
        send_a(16'hA53C, 16, 1'b0);
        a.out_ready_i = 1'b0;
        chk("mid_drain_valid", a.out_valid_o, 1);
        rst = 1'b1;
        #1;
        idle_a("rst_drain");
        @(negedge clk);
        rst = 1'b0;
        a.out_ready_i = 1'b1;
        repeat (2) @(negedge clk);
        idle_a("rst_drain_after");

        run_b(16'hC3A5, 8'hA5, 8'hC3);
        run_b(16'h810F, 8'h0F, 8'h81);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
